// File: rtl/matmul_ctrl_if.sv
// Controller-side bus of the matmul engine: job handshake, A/X memory reads,
// MAC lane control/results and result-memory writes.
interface matmul_ctrl_if #(
  parameter int ACC_W = 20
) ();
  logic             start;
  logic             busy;
  logic             done;
  logic             a_rd_en;
  logic [5:0]       a_addr;
  logic             x_rd_en;
  logic [2:0]       x_addr;
  logic             alu_en;
  logic [ACC_W-1:0] mu1, mu2, mu3, mu4, mu5, mu6, mu7;
  logic             r_we;
  logic [5:0]       r_addr;
  logic [ACC_W-1:0] r_wdata;

  modport master (
    input  start, mu1, mu2, mu3, mu4, mu5, mu6, mu7,
    output busy, done, a_rd_en, a_addr, x_rd_en, x_addr, alu_en,
           r_we, r_addr, r_wdata
  );

  modport slave (
    output start, mu1, mu2, mu3, mu4, mu5, mu6, mu7,
    input  busy, done, a_rd_en, a_addr, x_rd_en, x_addr, alu_en,
           r_we, r_addr, r_wdata
  );
endinterface

// File: rtl/matmul_ctrl.sv
// Row-sequencing controller for a 7-lane MAC datapath: streams A/X reads per row,
// captures the lane results and writes them out lane by lane.
module matmul_ctrl #(
  parameter int ROWS  = 7,
  parameter int KDEP  = 8,
  parameter int ACC_W = 20
) (
  input  logic          clk,
  input  logic          rst,
  matmul_ctrl_if.master bus
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PW = $clog2(KDEP + 1);

  typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;

  state_t           state_q, state_d;
  logic [RW-1:0]    row_q, row_d;
  logic [PW-1:0]    p_q, p_d;
  logic [2:0]       lane_q, lane_d;
  logic [ACC_W-1:0] buf_q [7];
  logic             cap;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      p_q     <= '0;
      lane_q  <= '0;
      for (int unsigned i = 0; i < 7; i++) buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      p_q     <= p_d;
      lane_q  <= lane_d;
      if (cap) begin
        buf_q[0] <= bus.mu1;
        buf_q[1] <= bus.mu2;
        buf_q[2] <= bus.mu3;
        buf_q[3] <= bus.mu4;
        buf_q[4] <= bus.mu5;
        buf_q[5] <= bus.mu6;
        buf_q[6] <= bus.mu7;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    p_d         = p_q;
    lane_d      = lane_q;
    cap         = 1'b0;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.a_rd_en = 1'b0;
    bus.a_addr  = '0;
    bus.x_rd_en = 1'b0;
    bus.x_addr  = '0;
    bus.alu_en  = 1'b0;
    bus.r_we    = 1'b0;
    bus.r_addr  = '0;
    bus.r_wdata = '0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = MAC;
          row_d   = '0;
          p_d     = '0;
        end
      end

      MAC: begin
        bus.busy = 1'b1;
        if (p_q != PW'(KDEP)) begin
          bus.a_rd_en = 1'b1;
          bus.x_rd_en = 1'b1;
          bus.a_addr  = 6'(row_q) * 6'(KDEP) + 6'(p_q);
          bus.x_addr  = 3'(p_q);
        end
        // MAC trails the reads by one cycle to match the memory read latency
        if (p_q != '0) bus.alu_en = 1'b1;
        if (p_q == PW'(KDEP)) begin
          cap     = 1'b1;
          lane_d  = '0;
          state_d = WRITE;
        end else begin
          p_d = p_q + PW'(1);
        end
      end

      WRITE: begin
        bus.busy    = 1'b1;
        bus.r_we    = 1'b1;
        bus.r_addr  = 6'(row_q) * 6'd7 + 6'(lane_q);
        bus.r_wdata = buf_q[lane_q];
        if (lane_q == 3'd6) begin
          if (row_q == RW'(ROWS - 1)) begin
            state_d = DONE;
          end else begin
            row_d   = row_q + RW'(1);
            p_d     = '0;
            state_d = MAC;
          end
        end else begin
          lane_d = lane_q + 3'd1;
        end
      end

      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_matmul_ctrl.sv
// Bench for matmul_ctrl: A/X memories and a 7-lane MAC model around the DUT,
// expected writes queued per job and checked by an independent monitor.
module tb_matmul_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matmul_ctrl_if #(.ACC_W(20)) bus ();

  matmul_ctrl #(.ROWS(7), .KDEP(8), .ACC_W(20)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [7:0]  amem [56];
  logic [7:0]  xmem [8][7];
  logic [7:0]  a_q;
  logic [7:0]  x_q  [7];
  logic [19:0] acc  [7];
  logic [19:0] mu   [7];

  always @(posedge clk) begin
    if (bus.a_rd_en) a_q <= amem[bus.a_addr];
    for (int l = 0; l < 7; l++) begin
      if (bus.x_rd_en) x_q[l] <= xmem[bus.x_addr][l];
      acc[l] <= bus.alu_en ? mu[l] : 20'd0;
    end
  end

  always_comb begin
    for (int l = 0; l < 7; l++) mu[l] = acc[l] + 20'(a_q) * 20'(x_q[l]);
  end

  assign bus.mu1 = mu[0];
  assign bus.mu2 = mu[1];
  assign bus.mu3 = mu[2];
  assign bus.mu4 = mu[3];
  assign bus.mu5 = mu[4];
  assign bus.mu6 = mu[5];
  assign bus.mu7 = mu[6];

  typedef struct {
    logic [5:0]  addr;
    logic [19:0] data;
  } wr_t;

  wr_t  expq [$];
  wr_t  mon_e;
  int   nchecks = 0;
  int   nerr    = 0;
  bit   mon_on  = 1'b0;
  logic [40:0] outs;

  assign outs = {bus.busy, bus.done, bus.a_rd_en, bus.x_rd_en, bus.alu_en, bus.r_we,
                 bus.a_addr, bus.x_addr, bus.r_addr, bus.r_wdata};

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Scoreboard monitor: every presented write is matched against the queue head
  always @(negedge clk) begin
    if (mon_on) begin
      if (bus.r_we) begin
        if (expq.size() == 0) begin
          nchecks++;
          nerr++;
          $display("FAIL unexpected_write: r_addr %0d r_wdata %0d with no write expected at %0t",
                   bus.r_addr, bus.r_wdata, $time);
        end else begin
          mon_e = expq.pop_front();
          chk("r_addr", 64'(bus.r_addr), 64'(mon_e.addr));
          chk("r_wdata", 64'(bus.r_wdata), 64'(mon_e.data));
        end
      end
      if (!bus.busy)
        chk("strobes_quiet_when_idle", {bus.r_we, bus.a_rd_en, bus.x_rd_en, bus.alu_en}, 64'd0);
    end
  end

  task automatic load(input int pat);
    for (int r = 0; r < 7; r++)
      for (int k = 0; k < 8; k++)
        amem[r*8+k] = (pat == 0) ? 8'd1 : (pat == 1) ? 8'd255 : 8'(r + 1);
    for (int k = 0; k < 8; k++)
      for (int l = 0; l < 7; l++)
        xmem[k][l] = (pat == 0) ? 8'd1 : (pat == 1) ? 8'd255 : 8'(l + 1);
  endtask

  task automatic push_exp(input int pat, input int nw);
    int r, l, d;
    for (int idx = 0; idx < nw; idx++) begin
      r = (idx % 49) / 7;
      l = idx % 7;
      d = (pat == 0) ? 8 : (pat == 1) ? 520200 : 8 * (r + 1) * (l + 1);
      expq.push_back('{addr: 6'(idx % 49), data: 20'(d)});
    end
  endtask

  function automatic void check_seq(input int cyc);
    int row, ph;
    row = (cyc - 1) / 16;
    ph  = (cyc - 1) % 16;
    chk("busy", 64'(bus.busy), 64'd1);
    chk("a_rd_en", 64'(bus.a_rd_en), 64'(ph < 8));
    chk("x_rd_en", 64'(bus.x_rd_en), 64'(ph < 8));
    chk("alu_en", 64'(bus.alu_en), 64'(ph >= 1 && ph <= 8));
    chk("r_we_phase", 64'(bus.r_we), 64'(ph >= 9));
    if (ph < 8) begin
      chk("a_addr", 64'(bus.a_addr), 64'(row * 8 + ph));
      chk("x_addr", 64'(bus.x_addr), 64'(ph));
    end
  endfunction

  task automatic run_job(input bit hold, input int extra_start, input int abort_at);
    int cyc;
    bit seen;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
    cyc  = 1;
    seen = 1'b0;
    while (cyc < 200) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      check_seq(cyc);
      if (extra_start != 0 && cyc == extra_start) bus.start = 1'b1;
      if (extra_start != 0 && cyc == extra_start + 1) bus.start = 1'b0;
      if (abort_at != 0 && cyc == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        chk("abort_outputs_zero", 64'(outs), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          chk("abort_quiet", {bus.done, bus.r_we, bus.busy}, 64'd0);
        end
        return;
      end
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", 64'(seen), 64'd1);
    chk("done_cycle", 64'(cyc), 64'd113);
    chk("busy_low_in_done", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int cyc;
    rst       = 1'b1;
    bus.start = 1'b0;
    load(0);
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'(outs), 64'd0);
    rst    = 1'b0;
    mon_on = 1'b1;

    // All-ones job: address/enable sequencing and value 8 everywhere
    push_exp(0, 49);
    run_job(1'b0, 0, 0);
    @(negedge clk);
    chk("done_one_cycle", {bus.done, bus.busy}, 64'd0);
    chk("queue_empty_ones", 64'(expq.size()), 64'd0);

    // All-255 job: largest sums must not truncate
    load(1);
    push_exp(1, 49);
    run_job(1'b0, 0, 0);
    chk("queue_empty_max", 64'(expq.size()), 64'd0);

    // Row/lane dependent data, with a stray start during row 3 MAC
    load(2);
    push_exp(2, 49);
    run_job(1'b0, 51, 0);
    @(negedge clk);
    chk("stray_start_ignored", 64'(bus.busy), 64'd0);
    chk("queue_empty_stray", 64'(expq.size()), 64'd0);

    // Reset in WRITE lane 3 of row 2 abandons the job, then a full rerun
    push_exp(2, 18);
    run_job(1'b0, 0, 45);
    chk("queue_empty_abort", 64'(expq.size()), 64'd0);
    push_exp(2, 49);
    run_job(1'b0, 0, 0);
    chk("queue_empty_rerun", 64'(expq.size()), 64'd0);

    // Start held high: done, one IDLE cycle, then the next job
    load(0);
    push_exp(0, 98);
    run_job(1'b1, 0, 0);
    @(negedge clk);
    chk("held_idle_gap", {bus.busy, bus.done}, 64'd0);
    @(negedge clk);
    chk("held_restart_busy", 64'(bus.busy), 64'd1);
    bus.start = 1'b0;
    cyc = 1;
    while (!bus.done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("held_second_done_cycle", 64'(cyc), 64'd113);
    repeat (5) begin
      @(negedge clk);
      chk("held_stays_idle", 64'(bus.busy), 64'd0);
    end
    chk("queue_empty_held", 64'(expq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule
